ula_sequencer: RTL and testbench

ULA_SEQUENCER -- requirements
Module: ula_sequencer

---
 rtl/ula_pkg.sv | 22 ++
 rtl/ula_sequencer.sv | 141 ++++++++++++++
 tb/tb_ula_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// ula_pkg -- shared types for the ULA sequencer.
//   op_e    : opcode presented to the downstream ALU (AND, OR, ADD, SUB)
//   state_e : command sequencing states (IDLE, EXEC, RESP)
//   DATA_W  : operand / accumulator width
package ula_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage : ula_pkg

// File: rtl/ula_sequencer.sv
// ula_sequencer -- accumulator-based command sequencer driving an external ALU.
//
// A command (operand + opcode, or a load) is accepted in IDLE, presented to the
// external ALU for one EXEC cycle, and the accumulator result is then offered
// in RESP until the consumer takes it. Fixed latency: handshake in cycle N,
// EXEC in N+1, response valid from N+2.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   clr               : synchronous clear of accumulator, flags, counter, FSM
//   in_valid/in_ready : command handshake (in_ready only in IDLE)
//   in_data, in_op    : operand B (or load value) and ALU opcode
//   in_load           : 1 = load in_data into the accumulator, no ALU operation
//   alu_a/alu_b/alu_f : operands and opcode towards the external ALU
//   alu_result/flag   : combinational result and overflow from the ALU
//   out_valid/ready   : response handshake (out_valid only in RESP)
//   out_data, out_ovf : accumulator and overflow of the last command
//   sticky_ovf        : OR of all overflows since reset or clear
//   op_count          : completed commands, modulo 256
module ula_sequencer
    import ula_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_op,
    input  logic              in_load,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_f,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_flag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf,
    output logic              sticky_ovf,
    output logic [7:0]        op_count
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] opnd_q;
    op_e               opc_q;
    logic              load_q;
    logic              last_ovf_q;
    logic              sticky_q;
    logic [7:0]        count_q;

    // Result and overflow of the command currently in EXEC.
    logic [DATA_W-1:0] exec_acc;
    logic              exec_ovf;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and EXEC result selection
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        exec_acc = load_q ? opnd_q : alu_result;
        exec_ovf = load_q ? 1'b0 : alu_flag;
        unique case (state_q)
            IDLE: if (in_valid) state_d = EXEC;
            EXEC: state_d = RESP;
            RESP: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // clr leaves the operand/opcode registers alone: they only feed alu_b and
    // alu_f, which keep showing the last latched command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            opnd_q     <= '0;
            opc_q      <= OP_AND;
            load_q     <= 1'b0;
            last_ovf_q <= 1'b0;
            sticky_q   <= 1'b0;
            count_q    <= '0;
        end else if (clr) begin
            acc_q      <= '0;
            last_ovf_q <= 1'b0;
            sticky_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        opnd_q <= in_data;
                        opc_q  <= op_e'(in_op);
                        load_q <= in_load;
                    end
                end
                EXEC: begin
                    acc_q      <= exec_acc;
                    last_ovf_q <= exec_ovf;
                    sticky_q   <= sticky_q | exec_ovf;
                    count_q    <= count_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == RESP);
    assign alu_a      = acc_q;
    assign alu_b      = opnd_q;
    assign alu_f      = opc_q;
    assign out_data   = acc_q;
    assign out_ovf    = last_ovf_q;
    assign sticky_ovf = sticky_q;
    assign op_count   = count_q;

endmodule : ula_sequencer

// File: tb/tb_ula_sequencer.sv
// tb_ula_sequencer -- self-checking bench for ula_sequencer.
// A behavioural ALU sits beside the sequencer on the alu_* ports. Expected
// responses come from an integer-arithmetic reference model and are queued
// when a command is accepted; a monitor compares them whenever out_valid=1.
module tb_ula_sequencer;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_op;
    logic       in_load;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_f;
    logic [7:0] alu_result;
    logic       alu_flag;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;
    logic       sticky_ovf;
    logic [7:0] op_count;

    ula_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_op      (in_op),
        .in_load    (in_load),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_f      (alu_f),
        .alu_result (alu_result),
        .alu_flag   (alu_flag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .sticky_ovf (sticky_ovf),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Existing ALU: bit-level signed overflow detection
    // ------------------------------------------------------------------
    always_comb begin
        alu_result = '0;
        alu_flag   = 1'b0;
        case (alu_f)
            2'b00: alu_result = alu_a & alu_b;
            2'b01: alu_result = alu_a | alu_b;
            2'b10: begin
                alu_result = alu_a + alu_b;
                alu_flag   = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            default: begin
                alu_result = alu_a - alu_b;
                alu_flag   = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Scoreboard and reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] data;
        logic       ovf;
        logic       sticky;
        logic [7:0] cnt;
    } resp_t;

    resp_t      sb[$];
    logic [7:0] m_acc;
    logic       m_sticky;
    int         m_cnt;
    int         n_vec;
    int         n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_acc    = '0;
        m_sticky = 1'b0;
        m_cnt    = 0;
        sb.delete();
    endfunction

    function automatic void model_cmd(input bit ld, input logic [7:0] d, input logic [1:0] op);
        int    a;
        int    b;
        int    r;
        bit    ovf;
        resp_t e;
        a   = int'($signed(m_acc));
        b   = int'($signed(d));
        ovf = 1'b0;
        if (ld) begin
            r = b;
        end else begin
            case (op)
                2'd0: r = int'($signed(m_acc & d));
                2'd1: r = int'($signed(m_acc | d));
                2'd2: r = a + b;
                default: r = a - b;
            endcase
            if (op[1]) ovf = (r > 127) || (r < -128);
        end
        m_acc    = 8'(r);
        m_sticky = m_sticky | ovf;
        m_cnt    = (m_cnt + 1) % 256;
        e.data   = m_acc;
        e.ovf    = ovf;
        e.sticky = m_sticky;
        e.cnt    = 8'(m_cnt);
        sb.push_back(e);
    endfunction

    // ------------------------------------------------------------------
    // Monitor: compares every cycle a response is presented
    // ------------------------------------------------------------------
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid) begin
                check("response expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb[0];
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_ovf", 32'(out_ovf), 32'(e.ovf));
                    check("sticky_ovf", 32'(sticky_ovf), 32'(e.sticky));
                    check("op_count", 32'(op_count), 32'(e.cnt));
                    check("in_ready in RESP", 32'(in_ready), 32'd0);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    // Waits for in_ready and offers a command; returns at the negedge just
    // before the accepting edge, with in_valid still asserted.
    task automatic start_cmd(input bit ld, input logic [7:0] d, input logic [1:0] op,
                             output logic [7:0] acc_before, output bit ok);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        ok = in_ready;
        if (!ok) begin
            check("in_ready wait timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid   = 1'b1;
        in_data    = d;
        in_op      = op;
        in_load    = ld;
        acc_before = m_acc;
        model_cmd(ld, d, op);
    endtask

    task automatic issue(input bit ld, input logic [7:0] d, input logic [1:0] op, input int hold);
        logic [7:0] acc_before;
        bit         ok;
        start_cmd(ld, d, op, acc_before, ok);
        if (!ok) return;
        @(negedge clk);
        // EXEC cycle: scramble the command inputs to prove they were latched.
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_op    = 2'($urandom);
        in_load  = 1'($urandom);
        check("EXEC in_ready", 32'(in_ready), 32'd0);
        check("EXEC out_valid", 32'(out_valid), 32'd0);
        check("EXEC alu_a", 32'(alu_a), 32'(acc_before));
        check("EXEC alu_b", 32'(alu_b), 32'(d));
        check("EXEC alu_f", 32'(alu_f), 32'(op));
        @(negedge clk);
        check("latency out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle out_valid", 32'(out_valid), 32'd0);
        check("idle in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        clr = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] acc_before;
        bit         ok;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = '0;
        in_load   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset op_count", 32'(op_count), 32'd0);
        check("reset alu_b", 32'(alu_b), 32'd0);
        rst_n = 1'b1;

        // Directed arithmetic cases.
        issue(1'b1, 8'd100, 2'b00, 0);
        issue(1'b0, 8'd50, 2'b10, 1);
        check("100+50 data", 32'(out_data), 32'(8'h96));
        check("100+50 ovf", 32'(out_ovf), 32'd1);
        check("100+50 sticky", 32'(sticky_ovf), 32'd1);
        issue(1'b1, 8'h0F, 2'b00, 0);
        issue(1'b0, 8'h3C, 2'b00, 2);
        check("0F&3C data", 32'(out_data), 32'(8'h0C));
        check("0F&3C ovf", 32'(out_ovf), 32'd0);
        issue(1'b1, 8'h0F, 2'b00, 0);
        issue(1'b0, 8'h30, 2'b01, 0);
        check("0F|30 data", 32'(out_data), 32'(8'h3F));
        check("0F|30 ovf", 32'(out_ovf), 32'd0);
        issue(1'b1, 8'h9C, 2'b00, 0);
        issue(1'b0, 8'd50, 2'b11, 0);
        check("-100-50 data", 32'(out_data), 32'd106);
        check("-100-50 ovf", 32'(out_ovf), 32'd1);

        // Back-pressure: response held for 5 cycles.
        issue(1'b0, 8'h11, 2'b10, 5);

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            issue(($urandom_range(0, 3) == 0), 8'($urandom), 2'($urandom), $urandom_range(0, 3));
        end

        // Reset asserted during EXEC aborts the command.
        start_cmd(1'b0, 8'h55, 2'b10, acc_before, ok);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst outputs zero",
              32'({alu_a, alu_b, alu_f, out_data, out_ovf, sticky_ovf, op_count} != '0), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post-rst out_valid", 32'(out_valid), 32'd0);
        end

        // clr while a response is pending.
        issue(1'b1, 8'h7F, 2'b00, 0);
        issue(1'b0, 8'h01, 2'b10, 0);
        start_cmd(1'b0, 8'h22, 2'b10, acc_before, ok);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("pre-clr out_valid", 32'(out_valid), 32'd1);
        clr = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        clr = 1'b0;
        check("clr out_valid", 32'(out_valid), 32'd0);
        check("clr out_data", 32'(out_data), 32'd0);
        check("clr sticky_ovf", 32'(sticky_ovf), 32'd0);
        check("clr op_count", 32'(op_count), 32'd0);
        check("clr in_ready", 32'(in_ready), 32'd1);

        // op_count wraps after 256 completed commands.
        do_clr();
        for (int i = 0; i < 256; i++) begin
            issue(($urandom_range(0, 3) == 0), 8'($urandom), 2'($urandom), 0);
        end
        check("op_count wrap", 32'(op_count), 32'd0);

        repeat (2) @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_ula_sequencer
